// File: rtl/bram_reduce_pkg.sv
// Shared types and helpers for the BRAM reduction engine.
package bram_reduce_pkg;

  typedef enum logic [1:0] {
    MODE_USUM = 2'd0,
    MODE_SSUM = 2'd1,
    MODE_UMAX = 2'd2,
    MODE_UMIN = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  localparam int IDENT_W = 128;

  // Accumulator start value; callers truncate to their accumulator width.
  function automatic logic [IDENT_W-1:0] ident(mode_t m, int acc_w);
    if (m == MODE_UMIN) return {IDENT_W{1'b1}} >> (IDENT_W - acc_w);
    return '0;
  endfunction

endpackage

// File: rtl/bram_reduce_rd_pipe.sv
// Tracks which BRAM read slots carry real data, RD_LAT cycles behind bram_en.
module bram_rd_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic in_valid,
  output logic out_valid
);

  logic [RD_LAT-1:0] taps;

  always_ff @(posedge clk) begin
    if (reset || flush) taps <= '0;
    else                taps <= RD_LAT'({taps, in_valid});
  end

  assign out_valid = taps[RD_LAT-1];

endmodule

// File: rtl/bram_reduce.sv
// Streams a BRAM window one word per cycle and folds it into a single
// sum/max/min result, with a done pulse and abort.
module bram_reduce
  import bram_reduce_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int ACC_W  = 48,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [1:0]        mode,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result,
  output logic              ovf
);

  state_t              state, state_next;
  mode_t               mode_q;
  logic [ADDR_W:0]     remaining;
  logic [1:0]          drain_cnt;
  logic [ACC_W-1:0]    acc, acc_next;
  logic                ovf_q, ovf_step;
  logic                rd_valid;
  logic                accept;

  logic signed [DATA_W-1:0] rdata_s;
  logic [ACC_W-1:0]    zext, sext, ssum;
  logic [ACC_W:0]      usum;

  assign accept = (state == S_IDLE) && start && !abort;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = (length == '0) ? S_FIN : S_ISSUE;
      S_ISSUE: if (remaining == (ADDR_W+1)'(1)) state_next = S_DRAIN;
      S_DRAIN: if (drain_cnt == 2'(RD_LAT - 1)) state_next = S_FIN;
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort) state_next = S_IDLE;
  end

  always_comb begin
    bram_en = (state == S_ISSUE);
    busy    = (state != S_IDLE);
    done    = (state == S_FIN);
  end

  bram_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk      (clk),
    .reset    (reset),
    .flush    (abort),
    .in_valid (bram_en),
    .out_valid(rd_valid)
  );

  assign rdata_s = bram_rdata;
  assign zext    = ACC_W'(bram_rdata);
  assign sext    = ACC_W'(rdata_s);
  assign usum    = {1'b0, acc} + {1'b0, zext};
  assign ssum    = acc + sext;

  always_comb begin
    acc_next = acc;
    ovf_step = 1'b0;
    case (mode_q)
      MODE_USUM: begin
        acc_next = usum[ACC_W-1:0];
        ovf_step = usum[ACC_W];
      end
      MODE_SSUM: begin
        acc_next = ssum;
        ovf_step = (acc[ACC_W-1] == sext[ACC_W-1]) && (ssum[ACC_W-1] != acc[ACC_W-1]);
      end
      MODE_UMAX: acc_next = (zext > acc) ? zext : acc;
      MODE_UMIN: acc_next = (zext < acc) ? zext : acc;
      default:   acc_next = acc;
    endcase
  end

  // Data arriving in the abort cycle is dropped along with the rest of the pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      bram_addr <= '0;
      remaining <= '0;
      drain_cnt <= '0;
      mode_q    <= MODE_USUM;
      acc       <= '0;
      ovf_q     <= 1'b0;
    end else if (accept) begin
      bram_addr <= base_addr;
      remaining <= length;
      drain_cnt <= '0;
      mode_q    <= mode_t'(mode);
      acc       <= ACC_W'(ident(mode_t'(mode), ACC_W));
      ovf_q     <= 1'b0;
    end else begin
      if (state == S_ISSUE) begin
        bram_addr <= bram_addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      if (state == S_DRAIN) drain_cnt <= drain_cnt + 1'b1;
      if (rd_valid && !abort) begin
        acc   <= acc_next;
        ovf_q <= ovf_q | ovf_step;
      end
    end
  end

  assign result = acc;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_bram_reduce.sv
// Scoreboard bench: three engines (RD_LAT 1/3/2, ACC_W 48/48/32) share one stimulus stream.
module tb_bram_reduce;

  localparam int DEPTH = 4096;
  localparam int NDUT  = 3;
  localparam int IDLE_LIMIT = 10000;

  typedef struct {
    logic [63:0] res;
    bit          ovf;
    int          done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [11:0] base_addr;
  logic [12:0] length;
  logic [1:0]  mode;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_on = 1'b0;
  bit [31:0] mem [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reduction straight from the rules: exact integer sums, then wrap to accw bits.
  function automatic void ref_model(input int m, input int b, input int n, input int accw,
                                    output logic [63:0] res, output bit o);
    logic [63:0]  mask, mx, mn;
    logic [127:0] us;
    longint       ss, hi, lo;
    bit           s_ovf;
    logic [31:0]  w;
    mask  = (64'd1 << accw) - 1;
    hi    = (longint'(1) << (accw - 1)) - 1;
    lo    = -(longint'(1) << (accw - 1));
    us    = '0;
    ss    = 0;
    s_ovf = 1'b0;
    mx    = '0;
    mn    = mask;
    for (int i = 0; i < n; i++) begin
      w  = mem[(b + i) % DEPTH];
      us = us + 128'(w);
      ss = ss + longint'(signed'(w));
      if (ss > hi || ss < lo) s_ovf = 1'b1;
      if (64'(w) > mx) mx = 64'(w);
      if (64'(w) < mn) mn = 64'(w);
    end
    case (m)
      0:       begin res = us[63:0] & mask;  o = (us >= (128'd1 << accw)); end
      1:       begin res = 64'(ss) & mask;   o = s_ovf; end
      2:       begin res = mx;               o = 1'b0; end
      default: begin res = mn;               o = 1'b0; end
    endcase
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : gd
    localparam int LAT  = (g == 0) ? 1 : (g == 1) ? 3 : 2;
    localparam int ACCW = (g == 2) ? 32 : 48;

    logic             bram_en, busy, done, ovf;
    logic [11:0]      bram_addr;
    logic [31:0]      bram_rdata;
    logic [ACCW-1:0]  result;
    logic [31:0]      pipe [LAT];

    exp_t        q[$];
    bit          mbusy = 1'b0;
    int          end_cyc = 0;
    int          rd_left = 0;
    logic [11:0] exp_addr = '0;

    bram_reduce #(.DATA_W(32), .ADDR_W(12), .ACC_W(ACCW), .RD_LAT(LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .base_addr (base_addr),
      .length    (length),
      .mode      (mode),
      .bram_en   (bram_en),
      .bram_addr (bram_addr),
      .bram_rdata(bram_rdata),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .ovf       (ovf)
    );

    // BRAM with LAT-cycle read latency; idle slots return garbage.
    always @(posedge clk) begin
      pipe[0] <= bram_en ? mem[bram_addr] : $urandom();
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bram_rdata = pipe[LAT-1];

    // Model: accepts starts, predicts result and done cycle, tracks expected reads.
    always @(posedge clk) begin
      exp_t e;
      if (rd_left > 0) begin
        rd_left--;
        exp_addr++;
      end
      if (reset || abort) begin
        q.delete();
        mbusy   = 1'b0;
        rd_left = 0;
      end else if (start && !mbusy) begin
        ref_model(int'(mode), int'(base_addr), int'(length), ACCW, e.res, e.ovf);
        e.done_cyc = (length == 0) ? cyc + 1 : cyc + int'(length) + LAT + 1;
        q.push_back(e);
        mbusy    = 1'b1;
        end_cyc  = e.done_cyc;
        rd_left  = int'(length);
        exp_addr = base_addr;
      end else if (mbusy && cyc == end_cyc) begin
        mbusy = 1'b0;
      end
    end

    // Monitor: compares outputs against the model every cycle and pops on done.
    always @(negedge clk) begin
      bit   exp_done;
      exp_t e;
      if (mon_on) begin
        check($sformatf("lat%0d_busy", LAT), 64'(busy), 64'(mbusy));
        check($sformatf("lat%0d_bram_en", LAT), 64'(bram_en), 64'(rd_left > 0));
        if (rd_left > 0) check($sformatf("lat%0d_bram_addr", LAT), 64'(bram_addr), 64'(exp_addr));
        exp_done = (q.size() > 0) && (q[0].done_cyc == cyc);
        check($sformatf("lat%0d_done", LAT), 64'(done), 64'(exp_done));
        if (exp_done) begin
          e = q.pop_front();
          check($sformatf("lat%0d_result", LAT), 64'(result), e.res);
          check($sformatf("lat%0d_ovf", LAT), 64'(ovf), 64'(e.ovf));
        end else if (q.size() > 0 && cyc > q[0].done_cyc) begin
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input int b, input int n, input int m);
    @(negedge clk);
    base_addr = 12'(b);
    length    = 13'(n);
    mode      = 2'(m);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    base_addr = 12'($urandom());
    length    = 13'($urandom());
    mode      = 2'($urandom());
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((gd[0].mbusy || gd[1].mbusy || gd[2].mbusy) && n < IDLE_LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_in_budget", 64'(n < IDLE_LIMIT), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input bit full);
    check({tag, "_busy0"}, 64'(gd[0].busy), 64'd0);
    check({tag, "_busy1"}, 64'(gd[1].busy), 64'd0);
    check({tag, "_busy2"}, 64'(gd[2].busy), 64'd0);
    check({tag, "_done_any"}, 64'(gd[0].done | gd[1].done | gd[2].done), 64'd0);
    check({tag, "_en_any"}, 64'(gd[0].bram_en | gd[1].bram_en | gd[2].bram_en), 64'd0);
    if (full) begin
      check({tag, "_addr0"}, 64'(gd[0].bram_addr), 64'd0);
      check({tag, "_addr1"}, 64'(gd[1].bram_addr), 64'd0);
      check({tag, "_result0"}, 64'(gd[0].result), 64'd0);
      check({tag, "_result1"}, 64'(gd[1].result), 64'd0);
      check({tag, "_result2"}, 64'(gd[2].result), 64'd0);
      check({tag, "_ovf_any"}, 64'(gd[0].ovf | gd[1].ovf | gd[2].ovf), 64'd0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    base_addr = '0; length = '0; mode = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    mon_on = 1'b1;
    checkOutput("reset", 1'b1);

    $display("[TB] usum of 0..1023");
    applyStimulus(0, 1024, 0);
    waitIdle();
    check("case1_result", 64'(gd[0].result), 64'd523776);

    $display("[TB] wrap past top of BRAM");
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'd1;
    applyStimulus(4090, 10, 0);
    waitIdle();
    check("case2_result", 64'(gd[1].result), 64'd10);

    $display("[TB] signed sum and max of all-ones words");
    for (int i = 100; i < 104; i++) mem[i] = 32'hFFFF_FFFF;
    applyStimulus(100, 4, 1);
    waitIdle();
    check("case3_ssum", 64'(gd[0].result), 64'hFFFF_FFFF_FFFC);
    applyStimulus(100, 4, 2);
    waitIdle();
    check("case3_umax", 64'(gd[1].result), 64'hFFFF_FFFF);

    $display("[TB] empty window");
    applyStimulus(5, 0, 3);
    waitIdle();
    check("case4_umin", 64'(gd[0].result), 64'hFFFF_FFFF_FFFF);

    $display("[TB] narrow accumulator overflow");
    for (int i = 200; i < 202; i++) mem[i] = 32'hFFFF_FFFF;
    applyStimulus(200, 2, 0);
    waitIdle();
    check("case5_result", 64'(gd[2].result), 64'hFFFF_FFFE);
    check("case5_ovf", 64'(gd[2].ovf), 64'd1);
    applyStimulus(0, 3, 0);
    check("case5_ovf_cleared", 64'(gd[2].ovf), 64'd0);
    waitIdle();

    $display("[TB] abort mid-run");
    applyStimulus(0, 100, 0);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort", 1'b0);
    repeat (120) @(negedge clk);

    $display("[TB] start while busy");
    applyStimulus(300, 50, 1);
    repeat (10) @(negedge clk);
    base_addr = 12'd7; length = 13'd5; mode = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle();

    $display("[TB] reset mid-run");
    applyStimulus(0, 200, 0);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midreset", 1'b1);

    $display("[TB] randomized windows");
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();
    applyStimulus(7, 4096, 0);
    waitIdle();
    for (int t = 0; t < 30; t++) begin
      applyStimulus($urandom_range(0, DEPTH - 1), $urandom_range(0, 64), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 6)) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      waitIdle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
